// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: one outstanding request on the SRAM-like
// instruction port, IF stall generation, and flush-safe response discard.
module inst_fetch_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              ce,
  input  logic              flush,
  input  logic              stall_i,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [DATA_W-1:0] inst_rdata,
  output logic              stallreq_if,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              adel_o
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [DATA_W-1:0]   hold_data_q;
  logic                drop_q;

  logic misaligned, deliver, from_pc, from_hold, dlv;

  assign misaligned = |pc[1:0];

  always_comb begin
    deliver   = 1'b0;
    from_pc   = 1'b0;
    from_hold = 1'b0;
    case (state_q)
      IDLE: if (ce && !flush && misaligned && !stall_i) begin
        deliver = 1'b1;
        from_pc = 1'b1;
      end
      WAIT: if (inst_data_ok && !flush && !stall_i) deliver = 1'b1;
      HOLD: if (ce && !flush && !stall_i) begin
        deliver   = 1'b1;
        from_hold = 1'b1;
      end
      default: ;
    endcase
  end

  // Gate with rst so every output reads 0 while reset is asserted.
  assign dlv          = deliver & rst;
  assign inst_valid_o = dlv;
  assign inst_o       = (!dlv || from_pc) ? '0 : (from_hold ? hold_data_q : inst_rdata);
  assign pc_o         = !dlv ? '0 : (from_pc ? pc : req_addr_q);
  assign adel_o       = dlv & from_pc;
  assign stallreq_if  = rst & ce & ~dlv;
  assign inst_req     = rst & (state_q == REQ);
  assign inst_addr    = req_addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      hold_data_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          drop_q <= 1'b0;
          if (ce && !flush && !misaligned) begin
            req_addr_q <= pc;
            state_q    <= REQ;
          end
        end
        REQ: begin
          // An accepted address must still drain its response, even if ce drops.
          if (!ce) begin
            state_q <= inst_addr_ok ? DROP : IDLE;
          end else begin
            if (flush) drop_q <= 1'b1;
            if (inst_addr_ok) state_q <= (drop_q || flush) ? DROP : WAIT;
          end
        end
        WAIT: begin
          if (inst_data_ok) begin
            if (flush) begin
              state_q <= IDLE;
            end else if (stall_i) begin
              hold_data_q <= inst_rdata;
              state_q     <= HOLD;
            end else begin
              state_q <= IDLE;
            end
          end else if (flush) begin
            state_q <= DROP;
          end
        end
        HOLD: if (!ce || flush || !stall_i) state_q <= IDLE;
        DROP: if (inst_data_ok) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed vector table, hand sequences for
// flush/slow-slave/async-reset, then random traffic against a transaction model.
module tb_inst_fetch_ctrl;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = '0;
  logic        ce = 1'b0, flush = 1'b0, stall_i = 1'b0;
  logic        inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        inst_req, stallreq_if, inst_valid_o, adel_o;
  logic [31:0] inst_addr, inst_o, pc_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_fetch_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .pc(pc), .ce(ce), .flush(flush), .stall_i(stall_i),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .stallreq_if(stallreq_if),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .pc_o(pc_o), .adel_o(adel_o)
  );

  typedef struct {
    logic ce, fl, st; logic [31:0] pc; logic aok, dok; logic [31:0] rd;
    logic req; logic [31:0] addr; logic sreq, vld; logic [31:0] inst, pco; logic adel;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input logic e_req, input logic [31:0] e_addr,
                     input logic e_stall, input logic e_vld, input logic [31:0] e_inst,
                     input logic [31:0] e_pc, input logic e_adel);
    logic ok;
    ok = (inst_req === e_req) && (!e_req || inst_addr === e_addr) &&
         (stallreq_if === e_stall) && (inst_valid_o === e_vld) &&
         (inst_o === e_inst) && (!e_vld || pc_o === e_pc) && (adel_o === e_adel);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got req=%0b addr=%h sreq=%0b vld=%0b inst=%h pc=%h adel=%0b; want req=%0b addr=%h sreq=%0b vld=%0b inst=%h pc=%h adel=%0b",
               nm, inst_req, inst_addr, stallreq_if, inst_valid_o, inst_o, pc_o, adel_o,
               e_req, e_addr, e_stall, e_vld, e_inst, e_pc, e_adel);
    end
  endtask

  task automatic drv(input logic c, input logic f, input logic s, input logic [31:0] p,
                     input logic aok, input logic dok, input logic [31:0] rd);
    @(negedge clk);
    ce = c; flush = f; stall_i = s; pc = p;
    inst_addr_ok = aok; inst_data_ok = dok; inst_rdata = rd;
    #1;
  endtask

  // Transaction-level reference: a fetch is in flight, has had its address
  // accepted, is doomed to be discarded, or is parked waiting for IF/ID.
  bit          m_busy, m_acc, m_doom, m_held;
  logic [31:0] m_addr, m_data;

  initial begin
    logic        r_ce, r_fl, r_st, r_aok, r_dok, e_vld, e_adel;
    logic [31:0] r_pc, r_rd, e_inst, e_pco;

    // Reset state
    ce = 1'b1; pc = 32'hBFC00000;
    #2;
    chk("reset_outs", L, 32'h0, L, L, 32'h0, 32'h0, L);
    total++;
    if (inst_addr !== 32'h0 || pc_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_addr: got inst_addr=%h pc_o=%h want 0", inst_addr, pc_o);
    end
    @(negedge clk); ce = 1'b0; rst = 1'b1;

    //          ce fl st pc            aok dok rd             req addr          sreq vld inst           pc_o          adel
    tbl[0]  = '{H, L, L, 32'hBFC00000, L,  L,  32'h0,         L,  32'h0,        H,   L,  32'h0,         32'h0,        L};
    tbl[1]  = '{H, L, L, 32'hBFC00000, H,  L,  32'h0,         H,  32'hBFC00000, H,   L,  32'h0,         32'h0,        L};
    tbl[2]  = '{H, L, L, 32'hBFC00004, L,  H,  32'h3C08BFC0,  L,  32'h0,        L,   H,  32'h3C08BFC0,  32'hBFC00000, L};
    tbl[3]  = '{H, L, L, 32'hBFC00002, L,  L,  32'h0,         L,  32'h0,        L,   H,  32'h0,         32'hBFC00002, H};
    tbl[4]  = '{H, L, L, 32'hBFC00004, L,  L,  32'h0,         L,  32'h0,        H,   L,  32'h0,         32'h0,        L};
    tbl[5]  = '{H, L, L, 32'hBFC00004, L,  L,  32'h0,         H,  32'hBFC00004, H,   L,  32'h0,         32'h0,        L};
    tbl[6]  = '{H, L, L, 32'hBFC00004, H,  L,  32'h0,         H,  32'hBFC00004, H,   L,  32'h0,         32'h0,        L};
    tbl[7]  = '{H, L, H, 32'hBFC00004, L,  H,  32'h24020001,  L,  32'h0,        H,   L,  32'h0,         32'h0,        L};
    tbl[8]  = '{H, L, H, 32'hBFC00004, L,  L,  32'h0,         L,  32'h0,        H,   L,  32'h0,         32'h0,        L};
    tbl[9]  = '{H, L, L, 32'hBFC00004, L,  L,  32'h0,         L,  32'h0,        L,   H,  32'h24020001,  32'hBFC00004, L};
    tbl[10] = '{H, L, L, 32'hBFC00008, L,  L,  32'h0,         L,  32'h0,        H,   L,  32'h0,         32'h0,        L};
    tbl[11] = '{H, L, L, 32'hBFC00008, H,  L,  32'h0,         H,  32'hBFC00008, H,   L,  32'h0,         32'h0,        L};
    tbl[12] = '{H, H, L, 32'hBFC00008, L,  L,  32'h0,         L,  32'h0,        H,   L,  32'h0,         32'h0,        L};
    tbl[13] = '{H, L, L, 32'hBFC00380, L,  L,  32'h0,         L,  32'h0,        H,   L,  32'h0,         32'h0,        L};
    tbl[14] = '{H, L, L, 32'hBFC00380, L,  H,  32'hDEADBEEF,  L,  32'h0,        H,   L,  32'h0,         32'h0,        L};
    tbl[15] = '{H, L, L, 32'hBFC00380, L,  L,  32'h0,         L,  32'h0,        H,   L,  32'h0,         32'h0,        L};
    tbl[16] = '{H, L, L, 32'hBFC00380, H,  L,  32'h0,         H,  32'hBFC00380, H,   L,  32'h0,         32'h0,        L};
    tbl[17] = '{H, L, L, 32'hBFC00384, L,  H,  32'h8C020000,  L,  32'h0,        L,   H,  32'h8C020000,  32'hBFC00380, L};

    foreach (tbl[i]) begin
      drv(tbl[i].ce, tbl[i].fl, tbl[i].st, tbl[i].pc, tbl[i].aok, tbl[i].dok, tbl[i].rd);
      chk($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].sreq, tbl[i].vld,
          tbl[i].inst, tbl[i].pco, tbl[i].adel);
    end

    // Flush while the address is still pending: request stays up, reply dropped
    drv(H, L, L, 32'h80000000, L, L, 32'h0);        chk("rqfl_idle", L, 0, H, L, 0, 0, L);
    drv(H, H, L, 32'h80000000, L, L, 32'h0);        chk("rqfl_flush", H, 32'h80000000, H, L, 0, 0, L);
    drv(H, L, L, 32'h80000100, L, L, 32'h0);        chk("rqfl_hold", H, 32'h80000000, H, L, 0, 0, L);
    drv(H, L, L, 32'h80000100, H, L, 32'h0);        chk("rqfl_aok", H, 32'h80000000, H, L, 0, 0, L);
    drv(H, L, L, 32'h80000100, L, H, 32'h12345678); chk("rqfl_drop", L, 0, H, L, 0, 0, L);
    drv(H, L, L, 32'h80000100, L, L, 32'h0);        chk("rqfl_idle2", L, 0, H, L, 0, 0, L);
    drv(H, L, L, 32'h80000100, H, L, 32'h0);        chk("rqfl_req2", H, 32'h80000100, H, L, 0, 0, L);
    drv(H, L, L, 32'h80000104, L, H, 32'hAABBCCDD); chk("rqfl_dlv", L, 0, L, H, 32'hAABBCCDD, 32'h80000100, L);

    // Slow slave
    drv(H, L, L, 32'h80000200, L, L, 32'h0); chk("slow_idle", L, 0, H, L, 0, 0, L);
    for (int k = 0; k < 3; k++) begin
      drv(H, L, L, 32'h80000200, L, L, 32'h0); chk($sformatf("slow_req%0d", k), H, 32'h80000200, H, L, 0, 0, L);
    end
    drv(H, L, L, 32'h80000200, H, L, 32'h0); chk("slow_aok", H, 32'h80000200, H, L, 0, 0, L);
    for (int k = 0; k < 4; k++) begin
      drv(H, L, L, 32'h80000200, L, L, 32'h0); chk($sformatf("slow_wait%0d", k), L, 0, H, L, 0, 0, L);
    end
    drv(H, L, L, 32'h80000204, L, H, 32'h0000000C); chk("slow_dlv", L, 0, L, H, 32'h0000000C, 32'h80000200, L);

    // Async reset in WAIT
    drv(H, L, L, 32'h80000300, L, L, 32'h0); chk("rst_idle", L, 0, H, L, 0, 0, L);
    drv(H, L, L, 32'h80000300, H, L, 32'h0); chk("rst_req", H, 32'h80000300, H, L, 0, 0, L);
    drv(H, L, L, 32'h80000300, L, L, 32'h0); chk("rst_wait", L, 0, H, L, 0, 0, L);
    #2 rst = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h55555555;
    #1 chk("rst_async", L, 0, L, L, 0, 0, L);
    total++;
    if (inst_addr !== 32'h0) begin
      bad++;
      $display("FAIL rst_async_addr: got %h want 00000000", inst_addr);
    end
    @(negedge clk); ce = 1'b0; inst_data_ok = 1'b0; rst = 1'b1;
    drv(H, L, L, 32'h80000400, L, L, 32'h0); chk("rst_after_idle", L, 0, H, L, 0, 0, L);
    drv(H, L, L, 32'h80000400, H, L, 32'h0); chk("rst_after_req", H, 32'h80000400, H, L, 0, 0, L);
    drv(H, L, L, 32'h80000404, L, H, 32'h01234567); chk("rst_after_dlv", L, 0, L, H, 32'h01234567, 32'h80000400, L);

    // Random traffic against the model
    @(negedge clk); rst = 1'b0; ce = 1'b0; inst_data_ok = 1'b0;
    @(negedge clk); rst = 1'b1;
    m_busy = 0; m_acc = 0; m_doom = 0; m_held = 0; m_addr = '0; m_data = '0;
    for (int n = 0; n < 3000; n++) begin
      r_ce  = ($urandom % 20) != 0;
      r_fl  = ($urandom % 10) == 0;
      r_st  = ($urandom % 3) == 0;
      r_pc  = $urandom;
      if (($urandom % 8) != 0) r_pc[1:0] = 2'b00;
      r_aok = $urandom % 2;
      r_dok = (m_busy && m_acc && !m_held) ? (($urandom % 3) == 0) : 1'b0;
      r_rd  = $urandom;
      drv(r_ce, r_fl, r_st, r_pc, r_aok, r_dok, r_rd);

      e_vld = 0; e_inst = '0; e_pco = '0; e_adel = 0;
      if (!m_busy) begin
        if (r_ce && !r_fl && r_pc[1:0] != 2'b00 && !r_st) begin e_vld = 1; e_pco = r_pc; e_adel = 1; end
      end else if (m_held) begin
        if (r_ce && !r_fl && !r_st) begin e_vld = 1; e_inst = m_data; e_pco = m_addr; end
      end else if (m_acc && !m_doom && r_dok && !r_fl && !r_st) begin
        e_vld = 1; e_inst = r_rd; e_pco = m_addr;
      end
      chk($sformatf("rand%0d", n), m_busy && !m_acc, m_addr, r_ce && !e_vld, e_vld, e_inst, e_pco, e_adel);

      if (!m_busy) begin
        if (r_ce && !r_fl && r_pc[1:0] == 2'b00) begin
          m_busy = 1; m_acc = 0; m_doom = 0; m_held = 0; m_addr = r_pc;
        end
      end else if (!m_acc) begin
        if (!r_ce) begin
          if (r_aok) begin m_acc = 1; m_doom = 1; end else m_busy = 0;
        end else begin
          if (r_fl) m_doom = 1;
          if (r_aok) m_acc = 1;
        end
      end else if (m_held) begin
        if (!r_ce || r_fl || !r_st) m_busy = 0;
      end else if (r_dok) begin
        if (m_doom || r_fl) m_busy = 0;
        else if (r_st) begin m_held = 1; m_data = r_rd; end
        else m_busy = 0;
      end else if (r_fl) begin
        m_doom = 1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
